ls_queue: RTL and testbench

LS_QUEUE -- requirements
Module: ls_queue

---
 rtl/ls_queue.sv | 247 ++++++++++++++++++++++++
 tb/tb_ls_queue.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ls_queue.sv
// In-order load/store queue: a circular buffer of rename-tagged entries that snoop the
// result broadcasts, issue strictly oldest-first to the memory unit and retire on completion.
module ls_queue #(
    parameter int DEPTH   = 8,
    parameter int DATA_W  = 32,
    parameter int TAG_W   = 4,
    parameter int NAME_W  = 5,
    parameter int OP_W    = 6,
    parameter int NUM_CDB = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        rdy,
    input  logic [NUM_CDB-1:0]          cdb_en,
    input  logic [NUM_CDB*TAG_W-1:0]    cdb_tag,
    input  logic [NUM_CDB*DATA_W-1:0]   cdb_data,
    input  logic                        alloc_en,
    input  logic [DATA_W-1:0]           alloc_op1,
    input  logic [DATA_W-1:0]           alloc_op2,
    input  logic [DATA_W-1:0]           alloc_imm,
    input  logic [TAG_W-1:0]            alloc_tag1,
    input  logic [TAG_W-1:0]            alloc_tag2,
    input  logic [TAG_W-1:0]            alloc_tagw,
    input  logic [NAME_W-1:0]           alloc_namew,
    input  logic [OP_W-1:0]             alloc_opc,
    input  logic                        flush,
    input  logic                        lsu_ready,
    input  logic                        lsu_done,
    output logic                        issue_en,
    output logic [DATA_W-1:0]           issue_op1,
    output logic [DATA_W-1:0]           issue_op2,
    output logic [DATA_W-1:0]           issue_imm,
    output logic [TAG_W-1:0]            issue_tagw,
    output logic [NAME_W-1:0]           issue_namew,
    output logic [OP_W-1:0]             issue_opc,
    output logic                        full,
    output logic                        empty,
    output logic [$clog2(DEPTH):0]      count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [TAG_W-1:0]  TAG_FREE = {TAG_W{1'b1}};
    localparam logic [OP_W-1:0]   OP_NOP   = {OP_W{1'b0}};
    localparam logic [PTR_W-1:0]  PTR_ZERO = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0]  PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DEPTH);
    localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};
    localparam logic [TAG_W-1:0]  TAG_ZERO  = {TAG_W{1'b0}};
    localparam logic [NAME_W-1:0] NAME_ZERO = {NAME_W{1'b0}};

    typedef struct packed {
        logic              valid;
        logic              issued;
        logic [TAG_W-1:0]  tag1;
        logic [DATA_W-1:0] op1;
        logic [TAG_W-1:0]  tag2;
        logic [DATA_W-1:0] op2;
        logic [DATA_W-1:0] imm;
        logic [TAG_W-1:0]  tagw;
        logic [NAME_W-1:0] namew;
        logic [OP_W-1:0]   opc;
    } entry_t;

    // Resolve one pending source against every broadcast channel; channel 0 is applied last so it wins.
    function automatic logic [TAG_W+DATA_W-1:0] snoop(
        input logic [TAG_W-1:0]          tag,
        input logic [DATA_W-1:0]         val,
        input logic [NUM_CDB-1:0]        en,
        input logic [NUM_CDB*TAG_W-1:0]  tags,
        input logic [NUM_CDB*DATA_W-1:0] datas
    );
        logic [TAG_W+DATA_W-1:0] res;
        res = {tag, val};
        for (int c = NUM_CDB - 1; c >= 0; c--) begin
            if (en[c] && (tag != TAG_FREE) && (tags[c*TAG_W +: TAG_W] == tag)) begin
                res = {TAG_FREE, datas[c*DATA_W +: DATA_W]};
            end
        end
        return res;
    endfunction

    entry_t            ent_q [DEPTH];
    entry_t            ent_d [DEPTH];
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  iss_q, iss_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              issue_en_q, issue_en_d;
    logic [DATA_W-1:0] issue_op1_q, issue_op1_d;
    logic [DATA_W-1:0] issue_op2_q, issue_op2_d;
    logic [DATA_W-1:0] issue_imm_q, issue_imm_d;
    logic [TAG_W-1:0]  issue_tagw_q, issue_tagw_d;
    logic [NAME_W-1:0] issue_namew_q, issue_namew_d;
    logic [OP_W-1:0]   issue_opc_q, issue_opc_d;

    logic   full_s;
    logic   alloc_ok_s;
    logic   retire_ok_s;
    logic   issue_ok_s;
    entry_t cand_s;
    entry_t new_ent_s;

    assign full_s = (count_q == CNT_FULL);

    // Next-state: snoop, in-order issue, retire at head, allocate at tail, flush override.
    always_comb begin
        ent_d         = ent_q;
        head_d        = head_q;
        iss_d         = iss_q;
        tail_d        = tail_q;
        issue_en_d    = 1'b0;
        issue_op1_d   = DATA_ZERO;
        issue_op2_d   = DATA_ZERO;
        issue_imm_d   = DATA_ZERO;
        issue_tagw_d  = TAG_ZERO;
        issue_namew_d = NAME_ZERO;
        issue_opc_d   = OP_NOP;
        new_ent_s     = '0;

        alloc_ok_s  = alloc_en && !full_s;
        retire_ok_s = lsu_done && ent_q[head_q].valid && ent_q[head_q].issued;

        for (int i = 0; i < DEPTH; i++) begin
            if (ent_q[i].valid) begin
                {ent_d[i].tag1, ent_d[i].op1} =
                    snoop(ent_q[i].tag1, ent_q[i].op1, cdb_en, cdb_tag, cdb_data);
                {ent_d[i].tag2, ent_d[i].op2} =
                    snoop(ent_q[i].tag2, ent_q[i].op2, cdb_en, cdb_tag, cdb_data);
            end else begin
                ent_d[i] = ent_q[i];
            end
        end

        // The candidate sees this cycle's captures, so a wake-up issues on the same edge.
        cand_s     = ent_d[iss_q];
        issue_ok_s = lsu_ready && cand_s.valid && !cand_s.issued &&
                     (cand_s.tag1 == TAG_FREE) && (cand_s.tag2 == TAG_FREE);

        if (issue_ok_s) begin
            ent_d[iss_q].issued = 1'b1;
            iss_d               = iss_q + PTR_ONE;
            issue_en_d          = 1'b1;
            issue_op1_d         = cand_s.op1;
            issue_op2_d         = cand_s.op2;
            issue_imm_d         = cand_s.imm;
            issue_tagw_d        = cand_s.tagw;
            issue_namew_d       = cand_s.namew;
            issue_opc_d         = cand_s.opc;
        end else begin
            iss_d = iss_q;
        end

        if (retire_ok_s) begin
            ent_d[head_q].valid  = 1'b0;
            ent_d[head_q].issued = 1'b0;
            head_d               = head_q + PTR_ONE;
        end else begin
            head_d = head_q;
        end

        new_ent_s.valid  = 1'b1;
        new_ent_s.issued = 1'b0;
        {new_ent_s.tag1, new_ent_s.op1} = snoop(alloc_tag1, alloc_op1, cdb_en, cdb_tag, cdb_data);
        {new_ent_s.tag2, new_ent_s.op2} = snoop(alloc_tag2, alloc_op2, cdb_en, cdb_tag, cdb_data);
        new_ent_s.imm    = alloc_imm;
        new_ent_s.tagw   = alloc_tagw;
        new_ent_s.namew  = alloc_namew;
        new_ent_s.opc    = alloc_opc;

        if (alloc_ok_s) begin
            ent_d[tail_q] = new_ent_s;
            tail_d        = tail_q + PTR_ONE;
        end else begin
            tail_d = tail_q;
        end

        count_d = count_q + CNT_W'(alloc_ok_s) - CNT_W'(retire_ok_s);

        if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_d[i].valid  = 1'b0;
                ent_d[i].issued = 1'b0;
            end
            head_d        = PTR_ZERO;
            iss_d         = PTR_ZERO;
            tail_d        = PTR_ZERO;
            count_d       = CNT_ZERO;
            issue_en_d    = 1'b0;
            issue_op1_d   = DATA_ZERO;
            issue_op2_d   = DATA_ZERO;
            issue_imm_d   = DATA_ZERO;
            issue_tagw_d  = TAG_ZERO;
            issue_namew_d = NAME_ZERO;
            issue_opc_d   = OP_NOP;
        end else begin
            count_d = count_d;
        end
    end

    // State register: reset first, then the global stall gates every update.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
            head_q        <= PTR_ZERO;
            iss_q         <= PTR_ZERO;
            tail_q        <= PTR_ZERO;
            count_q       <= CNT_ZERO;
            issue_en_q    <= 1'b0;
            issue_op1_q   <= DATA_ZERO;
            issue_op2_q   <= DATA_ZERO;
            issue_imm_q   <= DATA_ZERO;
            issue_tagw_q  <= TAG_ZERO;
            issue_namew_q <= NAME_ZERO;
            issue_opc_q   <= OP_NOP;
        end else if (rdy) begin
            ent_q         <= ent_d;
            head_q        <= head_d;
            iss_q         <= iss_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            issue_en_q    <= issue_en_d;
            issue_op1_q   <= issue_op1_d;
            issue_op2_q   <= issue_op2_d;
            issue_imm_q   <= issue_imm_d;
            issue_tagw_q  <= issue_tagw_d;
            issue_namew_q <= issue_namew_d;
            issue_opc_q   <= issue_opc_d;
        end
    end

    assign issue_en    = issue_en_q;
    assign issue_op1   = issue_op1_q;
    assign issue_op2   = issue_op2_q;
    assign issue_imm   = issue_imm_q;
    assign issue_tagw  = issue_tagw_q;
    assign issue_namew = issue_namew_q;
    assign issue_opc   = issue_opc_q;
    assign count       = count_q;
    assign full        = full_s;
    assign empty       = (count_q == CNT_ZERO);

endmodule

// File: tb/tb_ls_queue.sv
// Directed bench for ls_queue: fill/full, CDB wake-up and bypass, in-order issue,
// simultaneous alloc/issue/retire, wrap-around, flush, reset and stall.
module tb_ls_queue;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic [1:0]  cdb_en;
    logic [7:0]  cdb_tag;
    logic [63:0] cdb_data;
    logic        alloc_en;
    logic [31:0] alloc_op1, alloc_op2, alloc_imm;
    logic [3:0]  alloc_tag1, alloc_tag2, alloc_tagw;
    logic [4:0]  alloc_namew;
    logic [5:0]  alloc_opc;
    logic        flush, lsu_ready, lsu_done;
    logic        issue_en;
    logic [31:0] issue_op1, issue_op2, issue_imm;
    logic [3:0]  issue_tagw;
    logic [4:0]  issue_namew;
    logic [5:0]  issue_opc;
    logic        full, empty;
    logic [3:0]  count;

    int n_assert = 0;
    int n_fail   = 0;

    ls_queue dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .cdb_en(cdb_en), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .alloc_en(alloc_en), .alloc_op1(alloc_op1), .alloc_op2(alloc_op2), .alloc_imm(alloc_imm),
        .alloc_tag1(alloc_tag1), .alloc_tag2(alloc_tag2), .alloc_tagw(alloc_tagw),
        .alloc_namew(alloc_namew), .alloc_opc(alloc_opc),
        .flush(flush), .lsu_ready(lsu_ready), .lsu_done(lsu_done),
        .issue_en(issue_en), .issue_op1(issue_op1), .issue_op2(issue_op2), .issue_imm(issue_imm),
        .issue_tagw(issue_tagw), .issue_namew(issue_namew), .issue_opc(issue_opc),
        .full(full), .empty(empty), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rdy         = 1'b1;
        cdb_en      = 2'b00;
        cdb_tag     = 8'h00;
        cdb_data    = 64'h0;
        alloc_en    = 1'b0;
        alloc_op1   = 32'h0;
        alloc_op2   = 32'h0;
        alloc_imm   = 32'h0;
        alloc_tag1  = 4'hF;
        alloc_tag2  = 4'hF;
        alloc_tagw  = 4'h0;
        alloc_namew = 5'h0;
        alloc_opc   = 6'h0;
        flush       = 1'b0;
        lsu_ready   = 1'b0;
        lsu_done    = 1'b0;
    endtask

    task automatic alloc(input logic [31:0] op1, input logic [3:0] t1, input logic [3:0] t2,
                         input logic [5:0] opc);
        alloc_en    = 1'b1;
        alloc_op1   = op1;
        alloc_op2   = op1 ^ 32'hFFFF_0000;
        alloc_imm   = op1 + 32'd4;
        alloc_tag1  = t1;
        alloc_tag2  = t2;
        alloc_tagw  = op1[3:0];
        alloc_namew = op1[4:0];
        alloc_opc   = opc;
    endtask

    initial begin
        idle();
        rst = 1'b0;
        tick();
        tick();
        chk("rst_count", count, 64'd0);
        chk("rst_empty", empty, 64'd1);
        chk("rst_full", full, 64'd0);
        chk("rst_issue_en", issue_en, 64'd0);
        chk("rst_issue_opc", issue_opc, 64'd0);
        rst = 1'b1;

        // Fill all eight entries with the memory unit stalled, then try a ninth.
        for (int i = 0; i < 8; i++) begin
            alloc(32'd100 + 32'(i), 4'hF, 4'hF, 6'(i + 1));
            tick();
        end
        chk("fill_full", full, 64'd1);
        chk("fill_count", count, 64'd8);
        chk("fill_no_issue", issue_en, 64'd0);
        alloc(32'd999, 4'hF, 4'hF, 6'd9);
        tick();
        chk("ninth_count", count, 64'd8);
        chk("ninth_full", full, 64'd1);

        // Drain in order; entry 0 must still hold its original value.
        alloc_en  = 1'b0;
        lsu_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("drain_en", issue_en, 64'd1);
            chk("drain_op1", issue_op1, 64'(32'd100 + 32'(i)));
            chk("drain_opc", issue_opc, 64'(i + 1));
        end
        tick();
        chk("drain_idle_en", issue_en, 64'd0);
        chk("drain_idle_opc", issue_opc, 64'd0);
        lsu_ready = 1'b0;
        lsu_done  = 1'b1;
        for (int i = 0; i < 9; i++) tick();
        chk("retire_count", count, 64'd0);
        chk("retire_empty", empty, 64'd1);
        lsu_done = 1'b0;

        // A waits on tag 3; ready B behind it must not bypass.
        lsu_ready = 1'b1;
        alloc(32'h0, 4'd3, 4'hF, 6'd2);
        tick();
        chk("a_alloc_no_issue", issue_en, 64'd0);
        alloc(32'h0B0B, 4'hF, 4'hF, 6'd3);
        tick();
        chk("b_no_bypass", issue_en, 64'd0);
        alloc_en = 1'b0;
        tick();
        chk("b_no_bypass2", issue_en, 64'd0);
        cdb_en   = 2'b10;
        cdb_tag  = {4'd3, 4'd0};
        cdb_data = {32'h0000_1234, 32'h0};
        tick();
        chk("a_wake_en", issue_en, 64'd1);
        chk("a_wake_op1", issue_op1, 64'h1234);
        chk("a_wake_opc", issue_opc, 64'd2);
        cdb_en = 2'b00;
        tick();
        chk("b_issue_en", issue_en, 64'd1);
        chk("b_issue_op1", issue_op1, 64'h0B0B);
        chk("b_issue_imm", issue_imm, 64'h0B0F);
        lsu_done = 1'b1;
        tick();
        tick();
        lsu_done = 1'b0;
        chk("ab_retired", count, 64'd0);

        // Allocation-cycle bypass; both channels match, channel 0 wins.
        alloc(32'h11, 4'hF, 4'd5, 6'd4);
        cdb_en   = 2'b11;
        cdb_tag  = {4'd5, 4'd5};
        cdb_data = {32'h0000_DEAD, 32'h0000_BEEF};
        tick();
        chk("byp_alloc_no_issue", issue_en, 64'd0);
        alloc_en = 1'b0;
        cdb_en   = 2'b00;
        tick();
        chk("byp_issue_en", issue_en, 64'd1);
        chk("byp_op2", issue_op2, 64'hBEEF);
        chk("byp_op1", issue_op1, 64'h11);
        lsu_done = 1'b1;
        tick();
        lsu_done = 1'b0;
        chk("byp_retired", count, 64'd0);

        // Three entries, one issued, then alloc + issue + retire together.
        lsu_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            alloc(32'h21 + 32'(i), 4'hF, 4'hF, 6'd5);
            tick();
        end
        alloc_en  = 1'b0;
        lsu_ready = 1'b1;
        tick();
        chk("x1_issue", issue_op1, 64'h21);
        alloc(32'h24, 4'hF, 4'hF, 6'd6);
        lsu_done = 1'b1;
        tick();
        chk("triple_count", count, 64'd3);
        chk("triple_issue_en", issue_en, 64'd1);
        chk("triple_issue_op1", issue_op1, 64'h22);
        alloc_en = 1'b0;
        lsu_done = 1'b0;
        tick();
        chk("x3_issue", issue_op1, 64'h23);
        tick();
        chk("x4_issue", issue_op1, 64'h24);
        chk("x4_opc", issue_opc, 64'd6);
        chk("triple_count2", count, 64'd3);

        // Tail wraps 7 -> 0 while issuing and retiring.
        for (int i = 0; i < 5; i++) begin
            alloc(32'h30 + 32'(i), 4'hF, 4'hF, 6'd7);
            lsu_done = (i < 3);
            tick();
            if (i == 0) chk("wrap_first_idle", issue_en, 64'd0);
            else        chk("wrap_order", issue_op1, 64'(32'h30 + 32'(i - 1)));
        end
        alloc_en  = 1'b0;
        lsu_done  = 1'b0;
        lsu_ready = 1'b0;
        tick();
        chk("wrap_count", count, 64'd5);
        chk("wrap_hold_en", issue_en, 64'd0);

        // Flush beats alloc, retire and a pending issue.
        alloc(32'h40, 4'hF, 4'hF, 6'd8);
        lsu_done  = 1'b1;
        lsu_ready = 1'b1;
        flush     = 1'b1;
        tick();
        chk("flush_count", count, 64'd0);
        chk("flush_empty", empty, 64'd1);
        chk("flush_issue_en", issue_en, 64'd0);
        flush    = 1'b0;
        lsu_done = 1'b0;
        alloc(32'h55, 4'hF, 4'hF, 6'd9);
        tick();
        alloc_en = 1'b0;
        tick();
        chk("post_flush_issue", issue_op1, 64'h55);
        chk("post_flush_count", count, 64'd1);

        // Reset mid-operation, with stall asserted, wins.
        alloc(32'h66, 4'hF, 4'hF, 6'd10);
        tick();
        rst = 1'b0;
        rdy = 1'b0;
        tick();
        chk("midrst_count", count, 64'd0);
        chk("midrst_empty", empty, 64'd1);
        chk("midrst_issue_en", issue_en, 64'd0);
        chk("midrst_op1", issue_op1, 64'd0);
        rst = 1'b1;
        rdy = 1'b1;

        // Stall holds everything.
        lsu_ready = 1'b0;
        alloc(32'h77, 4'hF, 4'hF, 6'd11);
        tick();
        alloc_en  = 1'b0;
        rdy       = 1'b0;
        lsu_ready = 1'b1;
        tick();
        tick();
        chk("stall_issue_en", issue_en, 64'd0);
        chk("stall_count", count, 64'd1);
        rdy = 1'b1;
        tick();
        chk("unstall_issue", issue_op1, 64'h77);
        chk("unstall_en", issue_en, 64'd1);
        tick();
        chk("strobe_one_cycle", issue_en, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
